// File: rtl/hdp_reg_sequencer.sv
// Register-table sequencer feeding the HDP-1280-2 SPI master: one 16-bit write per table entry.
// Define HDP_SEQ_READBACK_EN to add a read-back and compare after every write.
module hdp_reg_sequencer #(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8192,
  parameter int unsigned GAP_CYCLES     = 16,
  // Derived from NUM_REGS; not meant to be overridden.
  parameter int unsigned IDX_W          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [IDX_W:0]   i_num_entries,
  output logic [IDX_W-1:0] o_tbl_index,
  input  logic [6:0]       i_tbl_addr,
  input  logic [7:0]       i_tbl_data,
  output logic             o_spi_start,
  output logic [7:0]       o_spi_tx_upper,
  output logic [7:0]       o_spi_tx_lower,
  input  logic             i_spi_complete,
  input  logic [7:0]       i_spi_rx_lower,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [IDX_W-1:0] o_err_index,
  output logic [1:0]       o_err_code
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W  = (CntMax > 2) ? $clog2(CntMax) : 1;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam logic [IDX_W:0]   NumRegsCnt  = (IDX_W + 1)'(NUM_REGS);
  localparam logic [IDX_W:0]   IdxOne      = (IDX_W + 1)'(1);
  localparam logic [1:0]       ErrTimeout  = 2'b01;
`ifdef HDP_SEQ_READBACK_EN
  localparam logic [1:0]       ErrReadback = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StFetch, StLatch, StStart, StWait, StGap, StDone, StError, StRbStart, StRbWait
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StFetch, StLatch, StStart, StWait, StGap, StDone, StError
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [IDX_W:0]   idx_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_upper_q, tx_upper_d;
  logic [7:0]       tx_lower_q, tx_lower_d;
  logic             spi_start_q, spi_start_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] err_index_q, err_index_d;
  logic [1:0]       err_code_q, err_code_d;
`ifdef HDP_SEQ_READBACK_EN
  logic [7:0]       wr_data_q, wr_data_d;
  // Set once the write of the current entry is through; the next GAP then advances.
  logic             rb_phase_q, rb_phase_d;
`else
  logic             unused_rx;
  assign unused_rx = ^i_spi_rx_lower;
`endif

  assign idx_inc = idx_q + IdxOne;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    cnt_d       = cnt_q;
    tx_upper_d  = tx_upper_q;
    tx_lower_d  = tx_lower_q;
    spi_start_d = 1'b0;
    done_d      = 1'b0;
    error_d     = error_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
`ifdef HDP_SEQ_READBACK_EN
    wr_data_d   = wr_data_q;
    rb_phase_d  = rb_phase_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          count_d     = (i_num_entries > NumRegsCnt) ? NumRegsCnt : i_num_entries;
          idx_d       = '0;
          cnt_d       = '0;
          error_d     = 1'b0;
          err_code_d  = 2'b00;
          err_index_d = '0;
`ifdef HDP_SEQ_READBACK_EN
          rb_phase_d  = 1'b0;
`endif
          state_d     = (i_num_entries == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        tx_upper_d = {1'b0, i_tbl_addr};
        tx_lower_d = i_tbl_data;
`ifdef HDP_SEQ_READBACK_EN
        wr_data_d  = i_tbl_data;
`endif
        state_d    = StStart;
      end
      StStart: begin
        spi_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = StWait;
      end
      StWait: begin
        if (i_spi_complete) begin
          cnt_d   = '0;
          state_d = StGap;
        end else if (cnt_q == TimeoutLast) begin
          error_d     = 1'b1;
          err_code_d  = ErrTimeout;
          err_index_d = idx_q[IDX_W-1:0];
          state_d     = StError;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
`ifdef HDP_SEQ_READBACK_EN
          if (!rb_phase_q) begin
            state_d = StRbStart;
          end else begin
            rb_phase_d = 1'b0;
            idx_d      = idx_inc;
            state_d    = (idx_inc == count_q) ? StDone : StFetch;
          end
`else
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? StDone : StFetch;
`endif
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`ifdef HDP_SEQ_READBACK_EN
      StRbStart: begin
        tx_upper_d  = {1'b1, tx_upper_q[6:0]};
        tx_lower_d  = 8'h00;
        spi_start_d = 1'b1;
        rb_phase_d  = 1'b1;
        cnt_d       = '0;
        state_d     = StRbWait;
      end
      StRbWait: begin
        if (i_spi_complete) begin
          cnt_d = '0;
          if (i_spi_rx_lower != wr_data_q) begin
            error_d     = 1'b1;
            err_code_d  = ErrReadback;
            err_index_d = idx_q[IDX_W-1:0];
            state_d     = StError;
          end else begin
            state_d = StGap;
          end
        end else if (cnt_q == TimeoutLast) begin
          error_d     = 1'b1;
          err_code_d  = ErrTimeout;
          err_index_d = idx_q[IDX_W-1:0];
          state_d     = StError;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`endif
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      StError: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      tx_upper_q  <= '0;
      tx_lower_q  <= '0;
      spi_start_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      err_code_q  <= '0;
`ifdef HDP_SEQ_READBACK_EN
      wr_data_q   <= '0;
      rb_phase_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      tx_upper_q  <= tx_upper_d;
      tx_lower_q  <= tx_lower_d;
      spi_start_q <= spi_start_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
`ifdef HDP_SEQ_READBACK_EN
      wr_data_q   <= wr_data_d;
      rb_phase_q  <= rb_phase_d;
`endif
    end
  end

  assign o_tbl_index    = idx_q[IDX_W-1:0];
  assign o_spi_start    = spi_start_q;
  assign o_spi_tx_upper = tx_upper_q;
  assign o_spi_tx_lower = tx_lower_q;
  assign o_busy         = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_err_index    = err_index_q;
  assign o_err_code     = err_code_q;

endmodule

// File: tb/tb_hdp_reg_sequencer.sv
// Scoreboard bench for hdp_reg_sequencer: table model, SPI master model, per-scenario tasks.
module tb_hdp_reg_sequencer;

  localparam int unsigned NumRegs  = 16;
  localparam int unsigned Timeout  = 8192;
  localparam int unsigned Gap      = 16;
  localparam int unsigned SpiDelay = 1400;
`ifdef HDP_SEQ_READBACK_EN
  localparam int unsigned TxnPerEntry = 2;
`else
  localparam int unsigned TxnPerEntry = 1;
`endif
  localparam int unsigned EntryBudget = TxnPerEntry * (SpiDelay + Gap + 8);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] num_entries;
  logic [3:0] tbl_index;
  logic [6:0] tbl_addr;
  logic [7:0] tbl_data;
  logic       spi_start;
  logic [7:0] tx_upper;
  logic [7:0] tx_lower;
  logic       spi_complete = 1'b0;
  logic [7:0] spi_rx = 8'h00;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] err_index;
  logic [1:0] err_code;

  hdp_reg_sequencer #(
    .NUM_REGS      (NumRegs),
    .TIMEOUT_CYCLES(Timeout),
    .GAP_CYCLES    (Gap)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_start       (start),
    .i_num_entries (num_entries),
    .o_tbl_index   (tbl_index),
    .i_tbl_addr    (tbl_addr),
    .i_tbl_data    (tbl_data),
    .o_spi_start   (spi_start),
    .o_spi_tx_upper(tx_upper),
    .o_spi_tx_lower(tx_lower),
    .i_spi_complete(spi_complete),
    .i_spi_rx_lower(spi_rx),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_err_index   (err_index),
    .o_err_code    (err_code)
  );

  always #5 clk = ~clk;

  // Register table with one cycle of read latency.
  logic [6:0] tbl_addr_mem [NumRegs];
  logic [7:0] tbl_data_mem [NumRegs];
  always @(posedge clk) begin
    tbl_addr <= tbl_addr_mem[tbl_index];
    tbl_data <= tbl_data_mem[tbl_index];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model and output monitor, both away from the active edge.
  int          txn_num      = 0;
  int          hang_txn     = -1;
  bit          rx_force     = 1'b0;
  logic [7:0]  rx_force_val = 8'h00;
  bit          spi_active   = 1'b0;
  int          spi_timer    = 0;
  logic [7:0]  last_wr      = 8'h00;
  int          done_count   = 0;
  int          err_rise_cyc = -1;
  logic        error_prev   = 1'b0;
  logic [15:0] obs_start_q [$];
  logic [15:0] obs_end_q [$];
  int          start_cyc_q [$];

  always @(negedge clk) begin
    spi_complete <= 1'b0;
    if (!rst_n) begin
      spi_active <= 1'b0;
    end else if (spi_start) begin
      obs_start_q.push_back({tx_upper, tx_lower});
      start_cyc_q.push_back(cyc);
      spi_active <= (txn_num != hang_txn);
      spi_timer  <= SpiDelay;
      txn_num    <= txn_num + 1;
      if (!tx_upper[7]) last_wr <= tx_lower;
    end else if (spi_active) begin
      if (spi_timer == 1) begin
        spi_complete <= 1'b1;
        spi_active   <= 1'b0;
        spi_rx       <= rx_force ? rx_force_val : last_wr;
        obs_end_q.push_back({tx_upper, tx_lower});
      end
      spi_timer <= spi_timer - 1;
    end
    if (done) done_count <= done_count + 1;
    if (error && !error_prev) err_rise_cyc <= cyc;
    error_prev <= error;
  end

  logic [15:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic load_table();
    for (int i = 0; i < NumRegs; i++) begin
      tbl_addr_mem[i] = 7'h00;
      tbl_data_mem[i] = 8'h00;
    end
    tbl_addr_mem[0] = 7'h01; tbl_data_mem[0] = 8'hA5;
    tbl_addr_mem[1] = 7'h02; tbl_data_mem[1] = 8'h3C;
    tbl_addr_mem[2] = 7'h7F; tbl_data_mem[2] = 8'hFF;
  endtask

  task automatic push_entry(input logic [6:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
`ifdef HDP_SEQ_READBACK_EN
    exp_q.push_back({1'b1, a, 8'h00});
`endif
  endtask

  task automatic pulse_start(input logic [4:0] n);
    @(negedge clk);
    num_entries = n;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ended);
    ended = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done || error) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num_entries = 5'd0;
    load_table();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if ({error, err_code, err_index} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_err: got err=%b code=%b idx=%0d want 0", error, err_code, err_index);
    end
    vectors++;
    if ({spi_start, tx_upper, tx_lower} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_spi: got start=%b tx=%h%h want 0", spi_start, tx_upper, tx_lower);
    end
    vectors++;
    if (tbl_index !== 4'd0) begin
      miscompares++; $display("FAIL reset_index: got %0d want 0", tbl_index);
    end
  endtask

  task automatic test_zero_entries();
    int base_s = obs_start_q.size();
    pulse_start(5'd0);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_early: got %b want 0", done); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", done); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width: got %b want 0", done); end
    repeat (20) @(negedge clk);
    vectors++;
    if (obs_start_q.size() - base_s !== 0) begin
      miscompares++; $display("FAIL zero_starts: got %0d want 0", obs_start_q.size() - base_s);
    end
  endtask

  task automatic test_three_entries();
    int base_s;
    int base_e;
    int base_d;
    bit ended;
    logic [15:0] got;
    load_table();
    hang_txn = -1;
    rx_force = 1'b0;
    exp_q.delete();
    push_entry(7'h01, 8'hA5);
    push_entry(7'h02, 8'h3C);
    push_entry(7'h7F, 8'hFF);
    base_s = obs_start_q.size();
    base_e = obs_end_q.size();
    base_d = done_count;
    pulse_start(5'd3);
    wait_end(3 * EntryBudget + 64, ended);
    vectors++;
    if (!ended) begin miscompares++; $display("FAIL three_finish: got no done/error, want done"); end
    vectors++;
    if (error !== 1'b0) begin miscompares++; $display("FAIL three_error: got %b want 0", error); end
    repeat (4) @(negedge clk);
    vectors++;
    if (done_count - base_d !== 1) begin
      miscompares++; $display("FAIL three_done_cycles: got %0d want 1", done_count - base_d);
    end
    vectors++;
    if (obs_start_q.size() - base_s !== exp_q.size()) begin
      miscompares++;
      $display("FAIL three_starts: got %0d want %0d", obs_start_q.size() - base_s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base_s + i < obs_start_q.size()) ? obs_start_q[base_s + i] : 16'hxxxx;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++; $display("FAIL three_word_at_start[%0d]: got %h want %h", i, got, exp_q[i]);
      end
      got = (base_e + i < obs_end_q.size()) ? obs_end_q[base_e + i] : 16'hxxxx;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++; $display("FAIL three_word_at_end[%0d]: got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int base_s;
    int base_d;
    int st_cyc;
    bit ended;
    load_table();
    rx_force = 1'b0;
    hang_txn = txn_num + TxnPerEntry;
    base_s = obs_start_q.size();
    base_d = done_count;
    pulse_start(5'd3);
    wait_end(EntryBudget + Timeout + 200, ended);
    @(negedge clk);
    vectors++;
    if (!ended) begin miscompares++; $display("FAIL timeout_finish: got no done/error, want error"); end
    vectors++;
    if ({error, err_code, err_index} !== {1'b1, 2'b01, 4'd1}) begin
      miscompares++;
      $display("FAIL timeout_err: got err=%b code=%b idx=%0d want err=1 code=01 idx=1",
               error, err_code, err_index);
    end
    st_cyc = (base_s + TxnPerEntry < start_cyc_q.size()) ? start_cyc_q[base_s + TxnPerEntry] : 0;
    vectors++;
    if (err_rise_cyc - st_cyc !== Timeout) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", err_rise_cyc - st_cyc, Timeout);
    end
    vectors++;
    if (obs_start_q.size() - base_s !== TxnPerEntry + 1) begin
      miscompares++;
      $display("FAIL timeout_starts: got %0d want %0d", obs_start_q.size() - base_s, TxnPerEntry + 1);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ({error, busy} !== 2'b10) begin
      miscompares++; $display("FAIL timeout_sticky: got err=%b busy=%b want err=1 busy=0", error, busy);
    end
    vectors++;
    if (done_count !== base_d) begin
      miscompares++; $display("FAIL timeout_done: got %0d pulses want 0", done_count - base_d);
    end
    hang_txn = -1;
  endtask

  task automatic test_busy_restart();
    int base_s;
    int base_d;
    bit ended;
    logic [15:0] got;
    load_table();
    exp_q.delete();
    push_entry(7'h01, 8'hA5);
    push_entry(7'h02, 8'h3C);
    push_entry(7'h7F, 8'hFF);
    base_s = obs_start_q.size();
    base_d = done_count;
    pulse_start(5'd3);
    vectors++;
    if ({error, err_code, busy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL restart_clear: got err=%b code=%b busy=%b want err=0 code=00 busy=1",
               error, err_code, busy);
    end
    for (int i = 0; i < 100 && obs_start_q.size() == base_s; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    pulse_start(5'd1);
    wait_end(3 * EntryBudget + 64, ended);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ended || error !== 1'b0 || done_count - base_d !== 1) begin
      miscompares++;
      $display("FAIL restart_finish: got ended=%b err=%b done=%0d want 1/0/1",
               ended, error, done_count - base_d);
    end
    vectors++;
    if (obs_start_q.size() - base_s !== exp_q.size()) begin
      miscompares++;
      $display("FAIL restart_starts: got %0d want %0d", obs_start_q.size() - base_s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base_s + i < obs_start_q.size()) ? obs_start_q[base_s + i] : 16'hxxxx;
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++; $display("FAIL restart_word[%0d]: got %h want %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int base_s;
    int base_d;
    bit ended;
    logic [15:0] got;
    load_table();
    base_s = obs_start_q.size();
    pulse_start(5'd3);
    for (int i = 0; i < 100 && obs_start_q.size() == base_s; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({busy, done, error, err_code, err_index, spi_start, tx_upper, tx_lower, tbl_index} !== 0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got busy=%b err=%b start=%b tx=%h%h idx=%0d want all 0",
               busy, error, spi_start, tx_upper, tx_lower, tbl_index);
    end
    repeat (3000) @(negedge clk);
    vectors++;
    if (obs_start_q.size() - base_s !== 1) begin
      miscompares++;
      $display("FAIL midreset_starts: got %0d want 1", obs_start_q.size() - base_s);
    end
    exp_q.delete();
    push_entry(7'h01, 8'hA5);
    base_s = obs_start_q.size();
    base_d = done_count;
    pulse_start(5'd1);
    wait_end(EntryBudget + 64, ended);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ended || error !== 1'b0 || done_count - base_d !== 1) begin
      miscompares++;
      $display("FAIL midreset_rerun: got ended=%b err=%b done=%0d want 1/0/1",
               ended, error, done_count - base_d);
    end
    got = (base_s < obs_start_q.size()) ? obs_start_q[base_s] : 16'hxxxx;
    vectors++;
    if (got !== exp_q[0]) begin
      miscompares++; $display("FAIL midreset_word: got %h want %h", got, exp_q[0]);
    end
  endtask

`ifdef HDP_SEQ_READBACK_EN
  task automatic test_readback();
    int base_s;
    int base_d;
    bit ended;
    logic [15:0] got;
    load_table();
    tbl_addr_mem[0] = 7'h05;
    tbl_data_mem[0] = 8'h12;
    exp_q.delete();
    push_entry(7'h05, 8'h12);
    for (int pass = 0; pass < 2; pass++) begin
      rx_force     = 1'b1;
      rx_force_val = (pass == 0) ? 8'h12 : 8'h13;
      base_s = obs_start_q.size();
      base_d = done_count;
      pulse_start(5'd1);
      wait_end(EntryBudget + 64, ended);
      repeat (4) @(negedge clk);
      vectors++;
      if (pass == 0 && (error !== 1'b0 || done_count - base_d !== 1)) begin
        miscompares++;
        $display("FAIL rb_match: got err=%b done=%0d want 0/1", error, done_count - base_d);
      end else if (pass == 1 && {error, err_code, err_index} !== {1'b1, 2'b10, 4'd0}) begin
        miscompares++;
        $display("FAIL rb_mismatch: got err=%b code=%b idx=%0d want 1/10/0",
                 error, err_code, err_index);
      end
      for (int i = 0; i < 2; i++) begin
        got = (base_s + i < obs_start_q.size()) ? obs_start_q[base_s + i] : 16'hxxxx;
        vectors++;
        if (got !== exp_q[i]) begin
          miscompares++; $display("FAIL rb_word[%0d]: got %h want %h", i, got, exp_q[i]);
        end
      end
    end
    rx_force = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero_entries();
    test_three_entries();
    test_timeout();
    test_busy_restart();
    test_mid_reset();
`ifdef HDP_SEQ_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
